// File: rtl/w5300_bus_responder_pkg.sv
// W5300: shared state, opcode and identity constants for the W5300 bus responder.
package W5300;
   typedef enum logic [2:0] {
      ST_CLEAR, ST_SETTLE, ST_IDLE, ST_READ, ST_WRITE, ST_WAIT, ST_HOLD
   } resp_state_e;
   typedef enum logic {ADDR_READ = 1'b0, ADDR_WRITE = 1'b1} AddrOperation;
   localparam int unsigned IDR_ADDR = 32'h3FE;
   localparam logic [15:0] CHIP_ID  = 16'h5300;
endpackage

// File: rtl/w5300_bus_responder_sync.sv
// w5300_bus_sync: parameterized-width two-flop synchronizer bank with a reset value.
module w5300_bus_sync #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s1_q, s2_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end
   assign q = s2_q;
endmodule

// File: rtl/w5300_bus_responder.sv
// w5300_bus_responder: device end of the W5300 direct-mode bus with reset, clear sweep and settle.
// Optional W5300_RESP_IDR_EN makes the IDR word read-only, returning the chip id.
module w5300_bus_responder
   import W5300::*;
#(
   parameter int DEPTH_LOG2    = 10,
   parameter int MIN_RST_TICKS = 100,
   parameter int SETTLE_TICKS  = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_rst_n,
   input  logic                  cs_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic [DEPTH_LOG2-1:0] addr,
   inout  wire  [15:0]           data,
   output logic                  ready,
   output logic                  evt_valid,
   output logic                  evt_wr,
   output logic [DEPTH_LOG2-1:0] evt_addr,
   output logic [15:0]           evt_data,
   output logic                  access_err
);
   localparam logic [15:0] MIN_M1    = 16'(MIN_RST_TICKS - 1);
   localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_TICKS - 1);

   logic                  w_rst_n_s, cs_n_s, rd_n_s, wr_n_s;
   logic [DEPTH_LOG2-1:0] addr_s;
   logic [15:0]           data_s;

   w5300_bus_sync #(.W(1), .RST_VAL(1'b1)) u_sync_rst (
      .clk(clk), .rst_n(rst_n), .d(w_rst_n), .q(w_rst_n_s));
   w5300_bus_sync #(.W(3), .RST_VAL(3'b111)) u_sync_ctl (
      .clk(clk), .rst_n(rst_n), .d({cs_n, rd_n, wr_n}), .q({cs_n_s, rd_n_s, wr_n_s}));
   w5300_bus_sync #(.W(DEPTH_LOG2)) u_sync_addr (
      .clk(clk), .rst_n(rst_n), .d(addr), .q(addr_s));
   w5300_bus_sync #(.W(16)) u_sync_data (
      .clk(clk), .rst_n(rst_n), .d(data), .q(data_s));

   resp_state_e           state_q, state_d;
   logic                  cs_n_prev_q, cs_n_prev_d;
   logic [DEPTH_LOG2-1:0] sweep_q, sweep_d, addr_lat_q, addr_lat_d;
   logic [15:0]           tick_q, tick_d, rst_cnt_q, rst_cnt_d;
   logic [15:0]           data_prev_q, data_prev_d, dout_q, dout_d, rdata_q;
   logic                  oe_q, oe_d, ready_q, ready_d, err_q, err_d;
   logic                  evt_valid_q, evt_valid_d;
   AddrOperation          evt_op_q, evt_op_d;
   logic [DEPTH_LOG2-1:0] evt_addr_q, evt_addr_d;
   logic [15:0]           evt_data_q, evt_data_d;
   logic                  cs_fall, cs_rise, hold_go, idr_hit, mem_we;
   logic [DEPTH_LOG2-1:0] mem_wa, ram_ra;
   logic [15:0]           mem_wd;
   logic [15:0]           mem [2**DEPTH_LOG2];

   assign cs_fall = cs_n_prev_q & ~cs_n_s;
   assign cs_rise = ~cs_n_prev_q & cs_n_s;
   assign hold_go = ~w_rst_n_s & (rst_cnt_q >= MIN_M1);

`ifdef W5300_RESP_IDR_EN
   localparam logic [DEPTH_LOG2-1:0] IDR_A = DEPTH_LOG2'(IDR_ADDR);
   assign idr_hit = addr_lat_q == IDR_A;
`else
   assign idr_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_CLEAR;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = hold_go                 ? ST_HOLD :
                state_q == ST_CLEAR     ? (&sweep_q ? ST_SETTLE : ST_CLEAR) :
                state_q == ST_SETTLE    ? (tick_q == SETTLE_M1 ? ST_IDLE : ST_SETTLE) :
                state_q == ST_IDLE      ? (!cs_fall ? ST_IDLE :
                                           rd_n_s == wr_n_s ? ST_WAIT :
                                           !rd_n_s ? ST_READ : ST_WRITE) :
                state_q == ST_HOLD      ? (w_rst_n_s ? ST_CLEAR : ST_HOLD) :
                cs_rise                 ? ST_IDLE : state_q;
   end

   // Leaving Hold clears word 0 on the way out so the sweep finishes one cycle sooner.
   always_comb begin
      cs_n_prev_d = cs_n_s;
      rst_cnt_d   = w_rst_n_s ? '0 : (&rst_cnt_q ? rst_cnt_q : rst_cnt_q + 16'd1);
      tick_d      = state_q == ST_SETTLE ? (&tick_q ? tick_q : tick_q + 16'd1) : '0;
      sweep_d     = hold_go ? '0 :
                    (state_q == ST_CLEAR || (state_q == ST_HOLD && w_rst_n_s)) ? sweep_q + 1'b1 : '0;
      addr_lat_d  = (state_q == ST_IDLE && cs_fall) ? addr_s : addr_lat_q;
      data_prev_d = data_s;
      mem_we      = state_q == ST_CLEAR || (state_q == ST_HOLD && state_d == ST_CLEAR) ||
                    (state_q == ST_WRITE && state_d == ST_IDLE && !idr_hit);
      mem_wa      = state_q == ST_WRITE ? addr_lat_q : sweep_q;
      mem_wd      = state_q == ST_WRITE ? data_prev_q : '0;
      ram_ra      = state_q == ST_IDLE ? addr_s : addr_lat_q;
   end

   always_comb begin
      ready_d     = state_q == ST_IDLE;
      oe_d        = state_q == ST_READ && state_d == ST_READ;
      dout_d      = state_q == ST_READ ? (idr_hit ? CHIP_ID : rdata_q) : dout_q;
      evt_valid_d = (state_q == ST_READ || state_q == ST_WRITE) && state_d == ST_IDLE;
      evt_op_d    = evt_valid_d ? (state_q == ST_WRITE ? ADDR_WRITE : ADDR_READ) : evt_op_q;
      evt_addr_d  = evt_valid_d ? addr_lat_q : evt_addr_q;
      evt_data_d  = evt_valid_d ? (state_q == ST_WRITE ? data_prev_q : dout_q) : evt_data_q;
      err_d       = hold_go ? 1'b0 :
                    err_q | (cs_fall & ((state_q != ST_IDLE) | (rd_n_s == wr_n_s)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_prev_q <= 1'b1;
         rst_cnt_q   <= '0;
         tick_q      <= '0;
         sweep_q     <= '0;
         addr_lat_q  <= '0;
         data_prev_q <= '0;
         dout_q      <= '0;
         oe_q        <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         evt_valid_q <= 1'b0;
         evt_op_q    <= ADDR_READ;
         evt_addr_q  <= '0;
         evt_data_q  <= '0;
      end else begin
         cs_n_prev_q <= cs_n_prev_d;
         rst_cnt_q   <= rst_cnt_d;
         tick_q      <= tick_d;
         sweep_q     <= sweep_d;
         addr_lat_q  <= addr_lat_d;
         data_prev_q <= data_prev_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         evt_valid_q <= evt_valid_d;
         evt_op_q    <= evt_op_d;
         evt_addr_q  <= evt_addr_d;
         evt_data_q  <= evt_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
      rdata_q <= mem[ram_ra];
   end

   assign data       = oe_q ? dout_q : 'z;
   assign ready      = ready_q;
   assign evt_valid  = evt_valid_q;
   assign evt_wr     = evt_op_q;
   assign evt_addr   = evt_addr_q;
   assign evt_data   = evt_data_q;
   assign access_err = err_q;
endmodule
